// File: rtl/mbinit_valtrain_pattern.sv
// VALTRAIN pattern generator and detector for the MBINIT.REPAIRVAL step.
// Define VAL_ERR_CNT_EN to add o_VAL_Err_Count (saturating count of tracked-iteration mismatches).
module mbinit_valtrain_pattern #(
   parameter int unsigned ITERATIONS = 128,
   parameter int unsigned THRESHOLD  = 16,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             i_Pattern_En,
   input  logic             i_Detect_En,
   input  logic             i_VAL_Rx,
   output logic             o_VAL_Tx,
   output logic             o_VAL_Pattern_done,
   output logic             o_VAL_Result,
   output logic             o_VAL_Result_valid
`ifdef VAL_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0] o_VAL_Err_Count
`endif
);

   localparam logic [1:0] G_IDLE = 2'd0;
   localparam logic [1:0] G_SEND = 2'd1;
   localparam logic [1:0] G_DONE = 2'd2;

   localparam logic [1:0] D_IDLE   = 2'd0;
   localparam logic [1:0] D_SEARCH = 2'd1;
   localparam logic [1:0] D_TRACK  = 2'd2;
   localparam logic [1:0] D_HOLD   = 2'd3;

   localparam logic [7:0]       PATTERN   = 8'hF0;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);
   localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       g_state_q, g_state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;

   logic [1:0]       d_state_q, d_state_d;
   logic [6:0]       sr_q, sr_d;
   logic [7:0]       win;
   logic [2:0]       phase_q, phase_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic             result_q, result_d;
   logic             valid_q, valid_d;
`ifdef VAL_ERR_CNT_EN
   logic [CNT_W-1:0] err_q, err_d;
`endif

   // Generator: bit_cnt_q/iter_cnt_q index the bit currently on o_VAL_Tx.
   always_comb begin
      g_state_d  = g_state_q;
      bit_cnt_d  = bit_cnt_q;
      iter_cnt_d = iter_cnt_q;
      tx_d       = 1'b0;
      done_d     = 1'b0;
      if (!i_Pattern_En) begin
         g_state_d  = G_IDLE;
         bit_cnt_d  = '0;
         iter_cnt_d = '0;
      end else begin
         case (g_state_q)
            G_IDLE: begin
               g_state_d  = G_SEND;
               bit_cnt_d  = '0;
               iter_cnt_d = '0;
               tx_d       = 1'b1;
            end
            G_SEND: begin
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = '0;
                  if (iter_cnt_q == LAST_ITER) begin
                     g_state_d  = G_DONE;
                     iter_cnt_d = '0;
                     done_d     = 1'b1;
                  end else begin
                     iter_cnt_d = iter_cnt_q + CNT_ONE;
                     tx_d       = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = ~bit_cnt_d[2];
               end
            end
            G_DONE: done_d = 1'b1;
            default: g_state_d = G_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         g_state_q  <= G_IDLE;
         bit_cnt_q  <= '0;
         iter_cnt_q <= '0;
         tx_q       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         g_state_q  <= g_state_d;
         bit_cnt_q  <= bit_cnt_d;
         iter_cnt_q <= iter_cnt_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   // sr_q keeps the 7 previous bits; the incoming bit completes the 8-bit window.
   assign win = {sr_q, i_VAL_Rx};

   always_comb begin
      d_state_d = d_state_q;
      sr_d      = sr_q;
      phase_d   = phase_q;
      run_d     = run_q;
      result_d  = result_q;
      valid_d   = valid_q;
`ifdef VAL_ERR_CNT_EN
      err_d     = err_q;
`endif
      case (d_state_q)
         D_IDLE, D_HOLD: begin
            if (i_Detect_En) begin
               d_state_d = D_SEARCH;
               sr_d      = {6'b0, i_VAL_Rx};
               phase_d   = '0;
               run_d     = '0;
               result_d  = 1'b0;
               valid_d   = 1'b0;
`ifdef VAL_ERR_CNT_EN
               err_d     = '0;
`endif
            end
         end
         D_SEARCH: begin
            if (!i_Detect_En) begin
               d_state_d = D_HOLD;
               valid_d   = 1'b1;
            end else begin
               sr_d = win[6:0];
               if (win == PATTERN) begin
                  d_state_d = D_TRACK;
                  run_d     = CNT_ONE;
                  phase_d   = '0;
               end
            end
         end
         D_TRACK: begin
            if (!i_Detect_En) begin
               d_state_d = D_HOLD;
               valid_d   = 1'b1;
            end else begin
               sr_d    = win[6:0];
               phase_d = phase_q + 3'd1;
               if (phase_q == 3'd7) begin
                  if (win == PATTERN) begin
                     if (run_q != RUN_MAX) run_d = run_q + CNT_ONE;
                  end else begin
                     d_state_d = D_SEARCH;
                     run_d     = '0;
                     phase_d   = '0;
`ifdef VAL_ERR_CNT_EN
                     if (err_q != '1) err_d = err_q + CNT_ONE;
`endif
                  end
               end
            end
         end
         default: d_state_d = D_IDLE;
      endcase
      // Sticky pass: a later mismatch resets run but never the result.
      if (run_d == RUN_MAX) result_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         d_state_q <= D_IDLE;
         sr_q      <= '0;
         phase_q   <= '0;
         run_q     <= '0;
         result_q  <= 1'b0;
         valid_q   <= 1'b0;
`ifdef VAL_ERR_CNT_EN
         err_q     <= '0;
`endif
      end else begin
         d_state_q <= d_state_d;
         sr_q      <= sr_d;
         phase_q   <= phase_d;
         run_q     <= run_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
`ifdef VAL_ERR_CNT_EN
         err_q     <= err_d;
`endif
      end
   end

   assign o_VAL_Tx           = tx_q;
   assign o_VAL_Pattern_done = done_q;
   assign o_VAL_Result       = result_q;
   assign o_VAL_Result_valid = valid_q;
`ifdef VAL_ERR_CNT_EN
   assign o_VAL_Err_Count    = err_q;
`endif

endmodule

// File: tb/tb_mbinit_valtrain_pattern.sv
// Directed self-checking bench for mbinit_valtrain_pattern (generator, detector, optional error count).
module tb_mbinit_valtrain_pattern;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic pattern_en = 1'b0;
   logic detect_en  = 1'b0;
   logic rx_drv     = 1'b0;
   logic loop_en    = 1'b0;
   logic rx;
   logic tx, done, result, valid;
`ifdef VAL_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   int checks = 0;
   int errors = 0;

   assign rx = loop_en ? tx : rx_drv;

   always #5 clk = ~clk;

   mbinit_valtrain_pattern dut (
      .CLK                (clk),
      .rst_n              (rst_n),
      .i_Pattern_En       (pattern_en),
      .i_Detect_En        (detect_en),
      .i_VAL_Rx           (rx),
      .o_VAL_Tx           (tx),
      .o_VAL_Pattern_done (done),
      .o_VAL_Result       (result),
      .o_VAL_Result_valid (valid)
`ifdef VAL_ERR_CNT_EN
      ,
      .o_VAL_Err_Count    (err_count)
`endif
   );

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; the bit is sampled by the following posedge.
   task automatic drive_bit(input logic b);
      rx_drv = b;
      @(negedge clk);
   endtask

   task automatic drive_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) drive_bit(b[i]);
   endtask

   task automatic drive_clean(input int n);
      for (int i = 0; i < n; i++) drive_byte(8'hF0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pattern_en = 1'b0; detect_en = 1'b0;
      wait_neg(2);
      checks++; if ({tx, done, result, valid} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b expected 0000", {tx, done, result, valid}); end
      rst_n = 1'b1; pattern_en = 1'b1;
      wait_neg(324);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL iter40_bit3_tx: got %b expected 1", tx); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({tx, done, result, valid} !== 4'b0000) begin errors++; $display("FAIL async_reset_outputs: got %b expected 0000", {tx, done, result, valid}); end
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL release_tx: got %b expected 0", tx); end
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL first_bit_after_reset: got %b expected 1", tx); end
      pattern_en = 1'b0;
      wait_neg(2);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL disable_tx: got %b expected 0", tx); end
   endtask

   task automatic test_full_pattern();
      logic [7:0] got;
      logic       done_seen;
      done_seen  = 1'b0;
      pattern_en = 1'b1;
      for (int it = 0; it < 128; it++) begin
         got = '0;
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            got = {got[6:0], tx};
            if (done) done_seen = 1'b1;
         end
         checks++; if (got !== 8'hF0) begin errors++; $display("FAIL full_iter_%0d: got %h expected f0", it, got); end
      end
      checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL full_done_early: got %b expected 0", done_seen); end
      @(negedge clk);
      checks++; if ({done, tx} !== 2'b10) begin errors++; $display("FAIL full_done: got done,tx=%b expected 10", {done, tx}); end
      wait_neg(3);
      checks++; if ({done, tx} !== 2'b10) begin errors++; $display("FAIL full_done_held: got done,tx=%b expected 10", {done, tx}); end
      pattern_en = 1'b0;
      @(negedge clk);
      checks++; if ({done, tx} !== 2'b00) begin errors++; $display("FAIL full_done_drop: got done,tx=%b expected 00", {done, tx}); end
   endtask

   task automatic test_loopback();
      loop_en = 1'b1; detect_en = 1'b1; pattern_en = 1'b1;
      wait_neg(128);
      checks++; if ({result, valid} !== 2'b00) begin errors++; $display("FAIL loop_run15: got result,valid=%b expected 00", {result, valid}); end
      @(negedge clk);
      checks++; if (result !== 1'b1) begin errors++; $display("FAIL loop_run16: got %b expected 1", result); end
      wait_neg(896);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL loop_done: got %b expected 1", done); end
      wait_neg(10);
      detect_en = 1'b0;
      @(negedge clk);
      checks++; if ({result, valid} !== 2'b11) begin errors++; $display("FAIL loop_hold: got result,valid=%b expected 11", {result, valid}); end
`ifdef VAL_ERR_CNT_EN
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL loop_err_count: got %0d expected 1", err_count); end
`endif
      pattern_en = 1'b0; loop_en = 1'b0;
      wait_neg(2);
   endtask

   task automatic test_threshold_fail();
      detect_en = 1'b1;
      drive_bit(1'b1);
      checks++; if ({result, valid} !== 2'b00) begin errors++; $display("FAIL rising_clear: got result,valid=%b expected 00", {result, valid}); end
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_clean(15);
      drive_byte(8'hE0);
      drive_clean(15);
      checks++; if ({result, valid} !== 2'b00) begin errors++; $display("FAIL fail_result: got result,valid=%b expected 00", {result, valid}); end
      detect_en = 1'b0;
      @(negedge clk);
      checks++; if ({result, valid} !== 2'b01) begin errors++; $display("FAIL fail_hold: got result,valid=%b expected 01", {result, valid}); end
`ifdef VAL_ERR_CNT_EN
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL fail_err_count: got %0d expected 1", err_count); end
`endif
      wait_neg(2);
   endtask

   task automatic test_threshold_pass();
      detect_en = 1'b1;
      drive_clean(15);
      drive_byte(8'hE0);
      drive_clean(15);
      checks++; if (result !== 1'b0) begin errors++; $display("FAIL pass_at_15: got %b expected 0", result); end
      drive_clean(1);
      checks++; if (result !== 1'b1) begin errors++; $display("FAIL pass_at_16: got %b expected 1", result); end
      drive_byte(8'hE0);
      drive_clean(1);
      checks++; if ({result, valid} !== 2'b10) begin errors++; $display("FAIL pass_sticky: got result,valid=%b expected 10", {result, valid}); end
      detect_en = 1'b0;
      @(negedge clk);
      checks++; if ({result, valid} !== 2'b11) begin errors++; $display("FAIL pass_hold: got result,valid=%b expected 11", {result, valid}); end
`ifdef VAL_ERR_CNT_EN
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL pass_err_count: got %0d expected 2", err_count); end
`endif
      drive_byte(8'h0F);
      checks++; if ({result, valid} !== 2'b11) begin errors++; $display("FAIL hold_frozen: got result,valid=%b expected 11", {result, valid}); end
   endtask

   task automatic test_abort_restart();
      logic [7:0] got;
      logic       done_seen;
      int         bad_iters;
      pattern_en = 1'b1;
      wait_neg(83);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_pre_tx: got %b expected 1", tx); end
      pattern_en = 1'b0;
      @(negedge clk);
      checks++; if ({done, tx} !== 2'b00) begin errors++; $display("FAIL abort_idle: got done,tx=%b expected 00", {done, tx}); end
      wait_neg(3);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL abort_idle_held: got %b expected 0", tx); end
      pattern_en = 1'b1;
      done_seen  = 1'b0;
      bad_iters  = 0;
      for (int it = 0; it < 128; it++) begin
         got = '0;
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            got = {got[6:0], tx};
            if (done) done_seen = 1'b1;
         end
         if (got !== 8'hF0) bad_iters++;
      end
      checks++; if (bad_iters !== 0) begin errors++; $display("FAIL restart_pattern: got %0d bad iterations expected 0", bad_iters); end
      checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL restart_done_early: got %b expected 0", done_seen); end
      @(negedge clk);
      checks++; if ({done, tx} !== 2'b10) begin errors++; $display("FAIL restart_done: got done,tx=%b expected 10", {done, tx}); end
      pattern_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_pattern();
      test_loopback();
      test_threshold_fail();
      test_threshold_pass();
      test_abort_restart();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
